// File: rtl/nw_pkg.sv
// nw_pkg: shared constants and state type for the Needleman-Wunsch score writer
package nw_pkg;
  localparam int BEAT_W = 512;
  localparam int PAGE_BEATS = 64;
  localparam logic [2:0] AXI_SIZE_64B = 3'b110;
  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_e;
endpackage

// File: rtl/HullFIFO.sv
// HullFIFO: first-word-fall-through FIFO with synchronous flush
module HullFIFO #(
  parameter int W = 8,
  parameter int LOG_DEPTH = 4
) (
  input  logic         clock,
  input  logic         reset_n,
  input  logic         clear,
  input  logic         push,
  input  logic [W-1:0] din,
  input  logic         pop,
  output logic [W-1:0] dout,
  output logic         full,
  output logic         empty
);
  logic [W-1:0] mem [2**LOG_DEPTH];
  logic [LOG_DEPTH:0] wp, rp;
  assign empty = wp == rp;
  assign full = (wp ^ rp) == {1'b1, {LOG_DEPTH{1'b0}}};
  assign dout = mem[rp[LOG_DEPTH-1:0]];
  always_ff @(posedge clock or negedge reset_n)
    if (!reset_n) begin
      wp <= '0;
      rp <= '0;
    end else if (clear) begin
      wp <= '0;
      rp <= '0;
    end else begin
      if (push && !full) wp <= wp + 1'b1;
      if (pop && !empty) rp <= rp + 1'b1;
    end
  always_ff @(posedge clock)
    if (push && !full) mem[wp[LOG_DEPTH-1:0]] <= din;
endmodule

// File: rtl/nw_score_packer.sv
// nw_score_packer: packs scores into beats, flushing a zero-padded partial beat at each row end
module nw_score_packer
  import nw_pkg::*;
#(
  parameter int SCORE_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clear,
  input  logic              en,
  input  logic [35:0]       row,
  input  logic [SCORE_W-1:0] score,
  input  logic              score_valid,
  output logic              beat_valid,
  output logic [BEAT_W-1:0] beat
);
  localparam int LANES = BEAT_W / SCORE_W;
  localparam int LW = $clog2(LANES);
  logic [BEAT_W-1:0] lanes, lanes_nxt;
  logic [LW-1:0] lane_idx;
  logic [35:0] row_cnt;
  logic take, row_end, flush;
  assign take = en && score_valid;
  assign row_end = row_cnt == row;
  assign flush = take && (lane_idx == LW'(LANES - 1) || row_end);
  always_comb begin
    lanes_nxt = lanes;
    lanes_nxt[int'(lane_idx) * SCORE_W +: SCORE_W] = score;
  end
  // lanes are cleared after every flush, so unused lanes of a row-end beat read as zero
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      lanes <= '0;
      lane_idx <= '0;
      row_cnt <= 36'd1;
      beat_valid <= 1'b0;
      beat <= '0;
    end else if (clear) begin
      lanes <= '0;
      lane_idx <= '0;
      row_cnt <= 36'd1;
      beat_valid <= 1'b0;
    end else begin
      beat_valid <= flush;
      if (flush) beat <= lanes_nxt;
      if (take) begin
        lanes <= flush ? '0 : lanes_nxt;
        lane_idx <= row_end ? '0 : lane_idx + 1'b1;
        row_cnt <= row_end ? 36'd1 : row_cnt + 36'd1;
      end
    end
endmodule

// File: rtl/nw_score_writer.sv
// nw_score_writer: packs grid scores into 512-bit beats and writes them as page-safe AXI4 bursts
module nw_score_writer
  import nw_pkg::*;
#(
  parameter int SCORE_W = 8,
  parameter int LOG_DEPTH = 6,
  parameter int MAX_OUTST = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cfg_start,
  input  logic [63:0]       cfg_addr,
  input  logic [31:0]       cfg_words,
  input  logic [35:0]       cfg_row,
  input  logic [SCORE_W-1:0] score,
  input  logic              score_valid,
  output logic [15:0]       awid,
  output logic [63:0]       awaddr,
  output logic [7:0]        awlen,
  output logic [2:0]        awsize,
  output logic              awvalid,
  input  logic              awready,
  output logic [BEAT_W-1:0] wdata,
  output logic [63:0]       wstrb,
  output logic              wlast,
  output logic              wvalid,
  input  logic              wready,
  input  logic [15:0]       bid,
  input  logic [1:0]        bresp,
  input  logic              bvalid,
  output logic              bready,
  output logic              credit_ret,
  output logic              busy,
  output logic              done,
  output logic              overflow,
  output logic              bresp_err,
  output logic [31:0]       beats_done
);
  localparam int QW = $clog2(MAX_OUTST);
  localparam int OW = QW + 1;
  localparam logic [OW-1:0] MAX_O = OW'(MAX_OUTST);
  state_e state, state_nxt;
  logic [63:0] aw_addr;
  logic [31:0] aw_left, words;
  logic [35:0] row;
  logic [OW-1:0] outstanding;
  logic [6:0] beat_in_burst, head_len, page_room, len;
  logic [BEAT_W-1:0] beat;
  logic start, beat_valid, fifo_full, fifo_empty, lq_full, lq_empty, aw_hs, w_hs;
  logic unused_ok;
  assign unused_ok = ^{bid, lq_full};
  assign start = cfg_start && (state == IDLE || state == DONE);
  assign busy = state == RUN || state == DRAIN;
  assign done = state == DONE;
  nw_score_packer #(.SCORE_W(SCORE_W)) u_packer (
    .clk(clk), .rst_n(rst_n), .clear(start), .en(busy), .row(row),
    .score(score), .score_valid(score_valid), .beat_valid(beat_valid), .beat(beat)
  );
  HullFIFO #(.W(BEAT_W), .LOG_DEPTH(LOG_DEPTH)) u_beat_fifo (
    .clock(clk), .reset_n(rst_n), .clear(start), .push(beat_valid), .din(beat),
    .pop(w_hs), .dout(wdata), .full(fifo_full), .empty(fifo_empty)
  );
  // one entry per accepted AW, so W can never run ahead of its address
  HullFIFO #(.W(7), .LOG_DEPTH(QW)) u_len_q (
    .clock(clk), .reset_n(rst_n), .clear(start), .push(aw_hs), .din(len),
    .pop(w_hs && wlast), .dout(head_len), .full(lq_full), .empty(lq_empty)
  );
  assign page_room = 7'(PAGE_BEATS) - {1'b0, aw_addr[11:6]};
  assign len = (aw_left < {25'd0, page_room}) ? aw_left[6:0] : page_room;
  assign awaddr = aw_addr;
  assign awlen = (aw_left == '0) ? '0 : {1'b0, len - 7'd1};
  assign awsize = AXI_SIZE_64B;
  assign awid = '0;
  assign awvalid = state == RUN && aw_left != '0 && outstanding < MAX_O;
  assign aw_hs = awvalid && awready;
  assign wvalid = !fifo_empty && !lq_empty;
  assign wlast = wvalid && beat_in_burst == head_len - 7'd1;
  assign wstrb = '1;
  assign w_hs = wvalid && wready;
  assign bready = 1'b1;
  always_comb begin
    state_nxt = start ? RUN : state;
    if (state == RUN && aw_left == '0) state_nxt = DRAIN;
    if (state == DRAIN && beats_done == words && outstanding == '0) state_nxt = DONE;
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state <= IDLE;
      aw_addr <= '0;
      aw_left <= '0;
      words <= '0;
      row <= '0;
      outstanding <= '0;
      beat_in_burst <= '0;
      beats_done <= '0;
      credit_ret <= 1'b0;
      overflow <= 1'b0;
      bresp_err <= 1'b0;
    end else begin
      state <= state_nxt;
      credit_ret <= w_hs;
      if (start) begin
        aw_addr <= cfg_addr;
        aw_left <= cfg_words;
        words <= cfg_words;
        row <= cfg_row;
        outstanding <= '0;
        beat_in_burst <= '0;
        beats_done <= '0;
        overflow <= 1'b0;
        bresp_err <= 1'b0;
      end else begin
        if (aw_hs) begin
          aw_addr <= aw_addr + {51'd0, len, 6'd0};
          aw_left <= aw_left - {25'd0, len};
        end
        outstanding <= outstanding + OW'(aw_hs) - OW'(bvalid);
        if (w_hs) beat_in_burst <= wlast ? '0 : beat_in_burst + 7'd1;
        beats_done <= beats_done + 32'(w_hs);
        overflow <= overflow | (beat_valid && fifo_full);
        bresp_err <= bresp_err | (bvalid && bresp != 2'b00);
      end
    end
endmodule

// File: tb/tb_nw_score_writer.sv
// tb_nw_score_writer: table-driven and randomized jobs checked against a burst/beat reference model
module tb_nw_score_writer;
  logic clk = 0, rst_n = 0;
  always #5 clk = ~clk;
  logic cfg_start = 0;
  logic [63:0] cfg_addr = 0;
  logic [31:0] cfg_words = 0;
  logic [35:0] cfg_row = 0;
  logic [7:0] score = 0;
  logic score_valid = 0;
  logic [15:0] awid;
  logic [63:0] awaddr;
  logic [7:0] awlen;
  logic [2:0] awsize;
  logic awvalid, awready = 0;
  logic [511:0] wdata;
  logic [63:0] wstrb;
  logic wlast, wvalid, wready = 0;
  logic [15:0] bid = 0;
  logic [1:0] bresp = 0;
  logic bvalid = 0, bready;
  logic credit_ret, busy, done, overflow, bresp_err;
  logic [31:0] beats_done;

  nw_score_writer dut (
    .clk(clk), .rst_n(rst_n), .cfg_start(cfg_start), .cfg_addr(cfg_addr), .cfg_words(cfg_words),
    .cfg_row(cfg_row), .score(score), .score_valid(score_valid), .awid(awid), .awaddr(awaddr),
    .awlen(awlen), .awsize(awsize), .awvalid(awvalid), .awready(awready), .wdata(wdata),
    .wstrb(wstrb), .wlast(wlast), .wvalid(wvalid), .wready(wready), .bid(bid), .bresp(bresp),
    .bvalid(bvalid), .bready(bready), .credit_ret(credit_ret), .busy(busy), .done(done),
    .overflow(overflow), .bresp_err(bresp_err), .beats_done(beats_done)
  );

  int checks = 0, failures = 0;
  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
    end
  endtask

  logic [63:0] got_aw_addr[$];
  int got_aw_len[$];
  logic [511:0] got_w[$];
  bit got_wlast[$];
  int credits = 0, aw_beats = 0, b_pending = 0, b_sent = 0, berr_idx = -1, aw_hold = 0, wpct = 80;
  bit prev_aw_stall = 0, prev_w_stall = 0, prev_whs = 0;
  logic [63:0] prev_awaddr;
  logic [7:0] prev_awlen;
  logic [511:0] prev_wdata;

  // bus monitor: samples on the falling edge, between handshake edges
  always @(negedge clk) begin
    if (!rst_n) begin
      prev_aw_stall = 0;
      prev_w_stall = 0;
      prev_whs = 0;
    end else begin
      if (prev_whs || credit_ret) chk("credit_ret", credit_ret, prev_whs);
      if (credit_ret) credits++;
      if (prev_aw_stall) begin
        chk("aw_hold_valid", awvalid, 1);
        chk("aw_hold_addr", awaddr, prev_awaddr);
        chk("aw_hold_len", awlen, prev_awlen);
      end
      if (prev_w_stall) begin
        chk("w_hold_valid", wvalid, 1);
        chk("w_hold_data", wdata == prev_wdata, 1);
      end
      if (bvalid) chk("bready", bready, 1);
      if (wvalid && wready) begin
        chk("w_after_aw", got_w.size() < aw_beats, 1);
        chk("wstrb", wstrb, '1);
        got_w.push_back(wdata);
        got_wlast.push_back(wlast);
        if (wlast) b_pending++;
      end
      if (awvalid && awready) begin
        chk("awsize", awsize, 3'b110);
        chk("awid", awid, 0);
        got_aw_addr.push_back(awaddr);
        got_aw_len.push_back(int'(awlen));
        aw_beats += int'(awlen) + 1;
      end
      prev_aw_stall = awvalid && !awready;
      prev_w_stall = wvalid && !wready;
      prev_whs = wvalid && wready;
      prev_awaddr = awaddr;
      prev_awlen = awlen;
      prev_wdata = wdata;
    end
  end

  // AXI slave: random ready, one B per completed burst
  initial forever begin
    @(posedge clk);
    #1;
    if (!rst_n) begin
      awready = 0;
      wready = 0;
      bvalid = 0;
    end else begin
      if (aw_hold > 0) begin
        awready = 0;
        aw_hold--;
      end else awready = ($urandom_range(0, 3) != 0);
      wready = ($urandom_range(0, 99) < wpct);
      bvalid = 0;
      if (b_pending > 0) begin
        bvalid = 1;
        bresp = (b_sent == berr_idx) ? 2'b10 : 2'b00;
        b_pending--;
        b_sent++;
      end
    end
  end

  task automatic chk_reset(input string t);
    chk({t, ".awvalid"}, awvalid, 0);
    chk({t, ".wvalid"}, wvalid, 0);
    chk({t, ".wlast"}, wlast, 0);
    chk({t, ".bready"}, bready, 1);
    chk({t, ".credit_ret"}, credit_ret, 0);
    chk({t, ".busy"}, busy, 0);
    chk({t, ".done"}, done, 0);
    chk({t, ".overflow"}, overflow, 0);
    chk({t, ".bresp_err"}, bresp_err, 0);
    chk({t, ".beats_done"}, beats_done, 0);
    chk({t, ".awaddr"}, awaddr, 0);
    chk({t, ".awlen"}, awlen, 0);
  endtask

  task automatic run_job(input string t, input logic [63:0] addr, input int words, input int row,
                         input int kind, input int hold, input int berr, input int exp_naw,
                         input int exp_len0, input bit gap, input bit abort);
    logic [7:0] s[$];
    logic [511:0] exp_w[$];
    logic [63:0] eb_addr[$];
    int eb_len[$];
    bit exp_last[$];
    logic [511:0] b;
    logic [63:0] a;
    int n, pos, rl, cnt, left, room, l, bpr;
    n = 0;
    if (words > 0) begin
      bpr = (row + 63) / 64;
      n = (words / bpr) * row + (words % bpr) * 64;
    end
    for (int i = 0; i < n; i++) s.push_back(kind == 0 ? 8'(i) : kind == 1 ? 8'hFF : 8'($urandom));
    // expected beats: each row cut into 64-score chunks; a chunk is emitted when full or at row end
    pos = 0;
    while (pos < n) begin
      rl = (n - pos < row) ? n - pos : row;
      for (int c = 0; c < rl; c += 64) begin
        cnt = (rl - c < 64) ? rl - c : 64;
        if (cnt == 64 || c + cnt == row) begin
          b = '0;
          for (int k = 0; k < cnt; k++) b[k*8 +: 8] = s[pos + c + k];
          exp_w.push_back(b);
        end
      end
      pos += rl;
    end
    a = addr;
    left = words;
    while (left > 0) begin
      room = 64 - int'(a[11:6]);
      l = left < room ? left : room;
      eb_addr.push_back(a);
      eb_len.push_back(l);
      for (int j = 0; j < l; j++) exp_last.push_back(j == l - 1);
      a += 64'(l) * 64;
      left -= l;
    end
    got_aw_addr.delete();
    got_aw_len.delete();
    got_w.delete();
    got_wlast.delete();
    credits = 0;
    aw_beats = 0;
    b_sent = 0;
    berr_idx = berr;
    aw_hold = hold;
    @(posedge clk);
    #1;
    cfg_addr = addr;
    cfg_words = 32'(words);
    cfg_row = 36'(row);
    cfg_start = 1;
    @(posedge clk);
    #1;
    cfg_start = 0;
    @(negedge clk);
    chk({t, ".busy"}, busy, 1);
    chk({t, ".beats_done0"}, beats_done, 0);
    @(posedge clk);
    #1;
    for (int i = 0; i < n; i++) begin
      score_valid = 1;
      score = s[i];
      @(posedge clk);
      #1;
      if (gap && $urandom_range(0, 3) == 0) begin
        score_valid = 0;
        @(posedge clk);
        #1;
      end
    end
    score_valid = 0;
    if (abort) begin
      for (int i = 0; i < 500 && !wvalid; i++) @(negedge clk);
      chk({t, ".wvalid"}, wvalid, 1);
      @(posedge clk);
      #2;
      rst_n = 0;
      #1;
      chk_reset({t, ".rst"});
      repeat (2) @(posedge clk);
      #3;
      b_pending = 0;
      rst_n = 1;
      return;
    end
    for (int i = 0; i < 20000 && !done; i++) @(negedge clk);
    chk({t, ".done"}, done, 1);
    chk({t, ".aw_count"}, got_aw_addr.size(), eb_addr.size());
    for (int i = 0; i < eb_addr.size() && i < got_aw_addr.size(); i++) begin
      chk($sformatf("%s.awaddr[%0d]", t, i), got_aw_addr[i], eb_addr[i]);
      chk($sformatf("%s.awlen[%0d]", t, i), got_aw_len[i], eb_len[i] - 1);
    end
    if (exp_naw >= 0) chk({t, ".tbl_naw"}, got_aw_addr.size(), exp_naw);
    if (exp_len0 >= 0 && got_aw_len.size() > 0) chk({t, ".tbl_awlen0"}, got_aw_len[0], exp_len0);
    chk({t, ".w_count"}, got_w.size(), words);
    for (int i = 0; i < words && i < got_w.size(); i++) begin
      chk($sformatf("%s.wlast[%0d]", t, i), got_wlast[i], exp_last[i]);
      checks++;
      if (got_w[i] !== exp_w[i]) begin
        failures++;
        $display("FAIL %s.wdata[%0d]: got %h expected %h", t, i, got_w[i], exp_w[i]);
      end
    end
    chk({t, ".beats_done"}, beats_done, words);
    chk({t, ".credits"}, credits, words);
    chk({t, ".overflow"}, overflow, 0);
    chk({t, ".bresp_err"}, bresp_err, berr >= 0 && berr < eb_addr.size());
    chk({t, ".busy_end"}, busy, 0);
  endtask

  typedef struct {
    logic [63:0] addr;
    int words, row, kind, hold, berr, exp_naw, exp_len0;
  } vec_t;
  vec_t vecs[7];

  initial begin
    vecs[0] = '{64'h1000, 2, 128, 0, 0, -1, 1, 1};
    vecs[1] = '{64'h1FC0, 3, 128, 0, 0, -1, 2, 0};
    vecs[2] = '{64'h4000, 1, 10, 1, 0, -1, 1, 0};
    vecs[3] = '{64'h8000, 64, 1, 0, 200, -1, 1, 63};
    vecs[4] = '{64'h2F80, 4, 64, 2, 0, 1, 2, 1};
    vecs[5] = '{64'h3000, 0, 10, 0, 0, -1, 0, -1};
    vecs[6] = '{64'h5F80, 5, 30, 0, 0, -1, 2, 1};
    repeat (3) @(posedge clk);
    #1;
    chk_reset("por");
    rst_n = 1;
    foreach (vecs[i])
      run_job($sformatf("tbl%0d", i), vecs[i].addr, vecs[i].words, vecs[i].row, vecs[i].kind,
              vecs[i].hold, vecs[i].berr, vecs[i].exp_naw, vecs[i].exp_len0, 0, 0);
    for (int r = 0; r < 8; r++)
      run_job($sformatf("rnd%0d", r), {44'($urandom_range(0, 255)), 6'($urandom_range(0, 63)), 6'd0},
              $urandom_range(1, 40), $urandom_range(1, 150), 2, $urandom_range(0, 30),
              $urandom_range(0, 1) ? -1 : $urandom_range(0, 2), -1, -1, 1, 0);
    wpct = 0;
    run_job("abort", 64'h6000, 4, 64, 0, 0, -1, -1, -1, 0, 1);
    wpct = 80;
    run_job("post", 64'h7FC0, 6, 64, 2, 0, -1, 2, 0, 1, 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
